// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM encoding and
// opcode classification helpers. The optional multiply-accumulate opcodes are
// only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE = 4'd0;
  localparam md_op_t MULT    = 4'd1;
  localparam md_op_t MULTU   = 4'd2;
  localparam md_op_t DIV     = 4'd3;
  localparam md_op_t DIVU    = 4'd4;
  localparam md_op_t MTHI    = 4'd5;
  localparam md_op_t MTLO    = 4'd6;
  localparam md_op_t MFHI    = 4'd7;
  localparam md_op_t MFLO    = 4'd8;
  localparam md_op_t MADD    = 4'd9;
  localparam md_op_t MADDU   = 4'd10;
  localparam md_op_t MSUB    = 4'd11;
  localparam md_op_t MSUBU   = 4'd12;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Ops that occupy the unit for a counted latency.
  function automatic logic is_multicycle(input md_op_t op);
    case (op)
      MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Ops that use the divide latency; everything else multicycle is a multiply.
  function automatic logic is_div(input md_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Any recognised MDU opcode; undefined codes are silently ignored.
  function automatic logic is_defined(input md_op_t op);
    return is_multicycle(op) || (op >= MTHI && op <= MFLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit HI/LO result for a latched MDU operation. Owns the
// divide-by-zero rule (no commit) and the signed-overflow quotient rule.
// Accumulate opcodes are evaluated only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        commit_en
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;

  // Products and quotients, selected by opcode; divide only when rt != 0.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    result    = {hi, lo};
    commit_en = 1'b0;
    quo_s     = '0;
    rem_s     = '0;
    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    prod_s    = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u    = {32'h0, rs} * {32'h0, rt};
    case (op)
      MULT: begin
        result    = prod_s;
        commit_en = 1'b1;
      end
      MULTU: begin
        result    = prod_u;
        commit_en = 1'b1;
      end
      DIV: begin
        if (rt == 32'h0) begin
          commit_en = 1'b0;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          result    = {32'h0, 32'h8000_0000};
          commit_en = 1'b1;
        end else begin
          quo_s     = $signed(rs) / $signed(rt);
          rem_s     = $signed(rs) % $signed(rt);
          result    = {rem_s, quo_s};
          commit_en = 1'b1;
        end
      end
      DIVU: begin
        if (rt != 32'h0) begin
          result    = {rs % rt, rs / rt};
          commit_en = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      MADD: begin
        result    = {hi, lo} + prod_s;
        commit_en = 1'b1;
      end
      MADDU: begin
        result    = {hi, lo} + prod_u;
        commit_en = 1'b1;
      end
      MSUB: begin
        result    = {hi, lo} - prod_s;
        commit_en = 1'b1;
      end
      MSUBU: begin
        result    = {hi, lo} - prod_u;
        commit_en = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// Multiply/divide sequencer beside the E-stage ALU: latches operands on issue,
// counts out MULT_CYCLES / DIV_CYCLES, commits HI/LO, and raises the D-stage
// stall request while occupied. Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] in_data_rs,
  input  logic [31:0] in_data_rt,
  input  logic        d_is_md,
  output logic [31:0] out_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err_issue
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;

  logic [63:0] arith_result;
  logic        arith_commit;

  mdu_arith u_arith (
    .op        (op_q),
    .rs        (rs_q),
    .rt        (rt_q),
    .hi        (hi_q),
    .lo        (lo_q),
    .result    (arith_result),
    .commit_en (arith_commit)
  );

  // State register plus the counter, latched operands and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: reset clears every register here, including HI/LO, so an abort leaves no stale result.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Next state: issue in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multicycle(md_op)) begin
            op_d    = md_op;
            rs_d    = in_data_rs;
            rt_d    = in_data_rt;
            cnt_d   = is_div(md_op) ? cnt_t'(DIV_CYCLES) : cnt_t'(MULT_CYCLES);
            state_d = RUN;
          end else if (md_op == MTHI) begin
            hi_d = in_data_rs;
          end else if (md_op == MTLO) begin
            lo_d = in_data_rs;
          end
        end
      end
      RUN: begin
        // The hazard unit should never let a new op reach E here.
        err_d = start && is_defined(md_op);
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = IDLE;
          if (arith_commit) begin
            {hi_d, lo_d} = arith_result;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status, stall request and the MFHI/MFLO read mux.
  always_comb begin
    busy      = (state_q == RUN);
    stall_req = d_is_md && (busy || (start && is_multicycle(md_op)));
    hi        = hi_q;
    lo        = lo_q;
    err_issue = err_q;
    case (md_op)
      MFHI:    out_md = hi_q;
      MFLO:    out_md = lo_q;
      default: out_md = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Scoreboard bench for mdu_scheduler: stimulus pushes the expected {hi,lo}
// and busy length of every multicycle op; a negedge monitor pops and compares
// each time busy falls. Status and zero-latency behaviour are checked inline.
module tb_mdu_scheduler;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] in_data_rs;
  logic [31:0] in_data_rt;
  logic        d_is_md;
  logic [31:0] out_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err_issue;

  typedef struct {
    logic [63:0] hilo;
    int          cycles;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   next_id = 0;
  logic busy_prev = 1'b0;
  int   busy_cnt  = 0;

  mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .md_op      (md_op),
    .in_data_rs (in_data_rs),
    .in_data_rt (in_data_rt),
    .d_is_md    (d_is_md),
    .out_md     (out_md),
    .busy       (busy),
    .stall_req  (stall_req),
    .hi         (hi),
    .lo         (lo),
    .err_issue  (err_issue)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] e_hi, input logic [31:0] e_lo, input int cyc);
    exp_t e;
    e.hilo   = {e_hi, e_lo};
    e.cycles = cyc;
    e.id     = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  // Drive one op for a single cycle; called #1 after a rising edge.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    md_op      = op;
    in_data_rs = a;
    in_data_rt = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("wait_idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  // Monitor: a falling busy outside reset is a commit point.
  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", {hi, lo}, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("commit%0d_hilo", e.id), {hi, lo}, e.hilo);
          check($sformatf("commit%0d_busy_cycles", e.id), 64'(busy_cnt), 64'(e.cycles));
        end
        busy_cnt = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE;
    in_data_rs = '0; in_data_rt = '0; d_is_md = 1'b0;
    #12;
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_err", {63'h0, err_issue}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // MULT -2 * 3 with stall request observed.
    d_is_md = 1'b1;
    md_op = MULT; in_data_rs = 32'hFFFF_FFFE; in_data_rt = 32'd3; start = 1'b1;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    #1 check("stall_on_issue", {63'h0, stall_req}, 64'h1);
    @(posedge clk);
    #1 start = 1'b0; md_op = MD_NONE;
    check("busy_after_issue", {63'h0, busy}, 64'h1);
    check("stall_while_busy", {63'h0, stall_req}, 64'h1);
    wait_idle();
    check("stall_released", {63'h0, stall_req}, 64'h0);
    d_is_md = 1'b0;
    md_op = MFHI;
    #1 check("mfhi", {32'h0, out_md}, 64'hFFFF_FFFF);
    md_op = MFLO;
    #1 check("mflo", {32'h0, out_md}, 64'hFFFF_FFFA);
    md_op = MD_NONE;

    // Divides.
    push_exp(32'd2, 32'd3, 10);
    issue(DIVU, 32'd17, 32'd5);
    wait_idle();
    push_exp(32'hFFFF_FFFE, 32'hFFFF_FFFD, 10);
    issue(DIV, 32'hFFFF_FFEF, 32'd5);
    wait_idle();
    push_exp(32'h0, 32'h8000_0000, 10);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    push_exp(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // MTHI/MTLO then divide by zero leaves them intact.
    issue(MTHI, 32'h11, 32'h0);
    check("mthi_busy", {63'h0, busy}, 64'h0);
    check("mthi_hi", {32'h0, hi}, 64'h11);
    issue(MTLO, 32'h22, 32'h0);
    check("mtlo_lo", {32'h0, lo}, 64'h22);
    push_exp(32'h11, 32'h22, 10);
    issue(DIV, 32'd100, 32'd0);
    wait_idle();

    // Issue during RUN is rejected with one error pulse; operands stay latched.
    push_exp(32'h0, 32'd42, 5);
    issue(MULT, 32'd7, 32'd6);
    in_data_rs = 32'd99;
    @(posedge clk);
    #1 start = 1'b1; md_op = DIV;
    @(posedge clk);
    #1 start = 1'b0; md_op = MD_NONE;
    check("err_pulse", {63'h0, err_issue}, 64'h1);
    @(posedge clk);
    #1 check("err_cleared", {63'h0, err_issue}, 64'h0);
    wait_idle();

    // Back-to-back: next op issued in the first idle cycle.
    push_exp(32'h0, 32'd6, 5);
    issue(MULTU, 32'd2, 32'd3);
    wait_idle();
    push_exp(32'd2, 32'd14, 10);
    issue(DIVU, 32'd100, 32'd7);
    check("b2b_accepted", {63'h0, busy}, 64'h1);
    wait_idle();

    // Reset during RUN aborts with no later commit.
    issue(DIV, 32'd100, 32'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("no_commit_after_abort", {hi, lo}, 64'h0);

    // Undefined opcode and the optional accumulate.
    issue(MTHI, 32'h0, 32'h0);
    issue(MTLO, 32'hFFFF_FFFF, 32'h0);
    issue(md_op_t'(4'd15), 32'h5, 32'h5);
    check("undef_busy", {63'h0, busy}, 64'h0);
    check("undef_err", {63'h0, err_issue}, 64'h0);
    check("undef_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`ifdef MDU_MADD_EN
    push_exp(32'h1, 32'h0, 5);
    issue(MADDU, 32'd1, 32'd1);
    wait_idle();
`else
    issue(MADDU, 32'd1, 32'd1);
    check("maddu_off_busy", {63'h0, busy}, 64'h0);
    repeat (6) @(posedge clk);
    #1 check("maddu_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Multi-cycle multiply/divide unit and its sequencer, placed beside the Execute-stage ALU.
- Accepts one HI/LO-class operation per issue from E, latches operands, and counts out a fixed latency before committing HI/LO.
- Drives the stall request that the hazard logic uses to hold D while the unit is occupied.
- Returns HI/LO to the pipeline for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op this cycle.
- md_op  in  4  operation code (package constants).
- in_data_rs  in  32  forwarded rs operand from E.
- in_data_rt  in  32  forwarded rt operand from E.
- d_is_md  in  1  instruction in D is any MDU op, including MF*/MT*.
- out_md  out  32  HI for MFHI, LO for MFLO, else 0; combinational from md_op and the HI/LO registers.
- busy  out  1  multi-cycle operation in progress.
- stall_req  out  1  = d_is_md & (busy | (start & op_is_multicycle)).
- hi  out  32  HI register.
- lo  out  32  LO register.
- err_issue  out  1  one-cycle pulse when start is seen while busy.

Behaviour:
- Reset (asynchronous): hi=0, lo=0, busy=0, counter=0, err_issue=0, state=IDLE, latched operands=0.
- States:
  - IDLE: start with MULT/MULTU/DIV/DIVU → latch rs, rt, op; load counter with MULT_CYCLES or DIV_CYCLES; go RUN. busy rises the cycle after start.
  - RUN: counter decrements each cycle. When counter==1, commit the result to HI/LO on that edge, clear busy, return to IDLE. Busy is high for exactly N cycles.
- Result rules:
  - MULT: {hi,lo} = signed 64-bit rs*rt.
  - MULTU: unsigned 64-bit product.
  - DIV: lo = signed quotient, hi = signed remainder, remainder sign follows the dividend (truncation toward zero).
  - DIVU: unsigned quotient and remainder.
  - Divisor 0: HI/LO unchanged; busy still runs the full DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: with start in IDLE, write rs to hi/lo on the next edge. Zero latency, busy stays 0.
- MFHI/MFLO: never change state. out_md reflects the registers in the same cycle.
- start in RUN: request ignored, no state change, err_issue pulses for one cycle. The hazard unit must make this unreachable.
- Operands are latched at issue, so later changes on in_data_rs/rt during RUN have no effect.
- Back-to-back: start in the cycle busy falls (IDLE again) is accepted normally. The counter reloads with no gap cycle.
- Reset during RUN: abort immediately; HI/LO go to 0 and no commit occurs.
- Undefined md_op with start: ignored, no error pulse.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined: opcodes MADD/MADDU/MSUB/MSUBU are accepted and use MULT_CYCLES latency. Commit is {hi,lo} ± product, with 64-bit wrap-around; the signed versions use a signed product.
- When undefined: these codes decode as undefined and are ignored.

Decomposition:
- Package mdu_pkg holds:
  - md_op constants: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State encoding: IDLE, RUN.
  - Helper function is_multicycle(op).
- One sub-module, mdu_arith: combinational 64-bit result from latched operands and op. It holds the divide-by-zero and overflow rules.
- The scheduler owns only the FSM, counter and registers.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req high while d_is_md=1 and busy.
- DIVU rs=17, rt=5 → busy 10 cycles; lo=3, hi=2. DIV rs=-17, rt=5 → lo=0xFFFFFFFD, hi=0xFFFFFFFE.
- DIV rt=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO → after 10 cycles hi=0x11, lo=0x22, busy cleared.
- MULT issued, start with DIV on cycle 2 → err_issue pulses once and the MULT result commits unchanged. A DIV issued the cycle busy falls is accepted.
- Reset asserted mid-RUN on cycle 3 of DIV → busy=0, hi=lo=0 immediately; no commit after reset release.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 → hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves HI/LO unchanged.
